// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame constants and
// the bit-period helper used by both the RX and (later) TX paths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  localparam int   UART_DATA_BITS = 8;
  localparam logic UART_IDLE      = 1'b1;

  // Whole clock cycles per bit; the fractional remainder is deliberately dropped.
  function automatic int clks_per_bit(input int clock_hz, input int baud);
    return clock_hz / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an occupancy counter. Full/empty come from the
// count so that equal read/write pointers are never ambiguous. A push into
// a full FIFO is only accepted when a pop frees the slot in the same cycle;
// otherwise it is reported on o_drop and the contents stay untouched.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_drop
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_doPop;
  logic w_doPush;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_doPop  = i_pop && !w_empty;
  assign w_doPush = i_push && (!w_full || w_doPop);

  assign o_drop  = i_push && !w_doPush;
  assign o_head  = r_mem[r_rdPtr];
  assign o_count = r_count;

  // Storage and pointers; storage is cleared so the head reads zero after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_doPush) begin
        r_mem[r_wrPtr] <= i_push_data;
        r_wrPtr        <= r_wrPtr + PTR_W'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
    end
  end

  // Occupancy: a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else begin
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a byte FIFO drained by valid/ready. The line is
// synchronised, frames are decoded by mid-bit sampling, and two sticky flags
// report dropped bytes (overrun) and low stop bits (frame_error).
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int CLOCK_HZ   = 27_000_000,
  parameter  int BAUD       = 115_200,
  parameter  int FIFO_DEPTH = 16,
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             uart_rx,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [CNT_W-1:0] fifo_count,
  output logic             overrun,
  output logic             frame_error,
  input  logic             clear_err
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_HZ, BAUD);
  localparam int BIT_CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = $clog2(UART_DATA_BITS);

  localparam logic [BIT_CNT_W-1:0] HALF_LAST = BIT_CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_CNT_W-1:0] FULL_LAST = BIT_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(UART_DATA_BITS - 1);

  logic                      r_rxMeta;
  logic                      r_rxS;
  rx_state_t                 r_state;
  logic [BIT_CNT_W-1:0]      r_bitCnt;
  logic [IDX_W-1:0]          r_bitIdx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic                      r_overrun;
  logic                      r_frameError;

  logic w_halfTick;
  logic w_fullTick;
  logic w_stopSample;
  logic w_push;
  logic w_badStop;
  logic w_drop;

  assign w_halfTick   = (r_bitCnt == HALF_LAST);
  assign w_fullTick   = (r_bitCnt == FULL_LAST);
  assign w_stopSample = (r_state == STOP) && w_fullTick;
  assign w_push       = w_stopSample && r_rxS;
  assign w_badStop    = w_stopSample && !r_rxS;

  // Two-flop synchroniser; resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rxMeta <= UART_IDLE;
      r_rxS    <= UART_IDLE;
    end else begin
      r_rxMeta <= uart_rx;
      r_rxS    <= r_rxMeta;
    end
  end

  // Frame decoder: the bit counter restarts on every state change or bit, and the FSM leaves STOP at mid-bit so a following start edge is never missed.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_bitCnt <= '0;
      r_bitIdx <= '0;
      r_shift  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_bitCnt <= '0;
          if (!r_rxS) begin
            r_state <= START;
          end
        end
        START: begin
          if (w_halfTick) begin
            r_bitCnt <= '0;
            r_bitIdx <= '0;
            r_state  <= r_rxS ? IDLE : DATA;
          end else begin
            r_bitCnt <= r_bitCnt + BIT_CNT_W'(1);
          end
        end
        DATA: begin
          if (w_fullTick) begin
            r_bitCnt <= '0;
            r_shift  <= {r_rxS, r_shift[UART_DATA_BITS-1:1]};
            if (r_bitIdx == LAST_IDX) begin
              r_state <= STOP;
            end else begin
              r_bitIdx <= r_bitIdx + IDX_W'(1);
            end
          end else begin
            r_bitCnt <= r_bitCnt + BIT_CNT_W'(1);
          end
        end
        STOP: begin
          if (w_fullTick) begin
            r_bitCnt <= '0;
            r_state  <= r_rxS ? IDLE : WAIT_HIGH;
          end else begin
            r_bitCnt <= r_bitCnt + BIT_CNT_W'(1);
          end
        end
        WAIT_HIGH: begin
          r_bitCnt <= '0;
          if (r_rxS) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_bitCnt <= '0;
        end
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_push      (w_push),
    .i_push_data (r_shift),
    .i_pop       (rd_ready),
    .o_head      (rd_data),
    .o_count     (fifo_count),
    .o_drop      (w_drop)
  );

  assign rd_valid = (fifo_count != '0);

  // Sticky error flags; a new error in the same cycle as clear_err keeps the flag set.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_overrun    <= 1'b0;
      r_frameError <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (clear_err) begin
        r_overrun <= 1'b0;
      end
      if (w_badStop) begin
        r_frameError <= 1'b1;
      end else if (clear_err) begin
        r_frameError <= 1'b0;
      end
    end
  end

  assign overrun     = r_overrun;
  assign frame_error = r_frameError;

endmodule
